// File: rtl/da_pkg.sv
// Shared definitions for the da_wavegen waveform generator.
//   mode_e : waveform selection (saw up, saw down, triangle, square)
//   dir_e  : triangle sweep direction
//   cfg_t  : one configuration set (mode, prescaler divisor, square duty)
// cfg_t fields are sized for the widest supported build (WIDTH <= MAX_WIDTH,
// DIV_W <= MAX_DIV_W); narrower instances store zero-extended values.
package da_pkg;

  localparam int MAX_WIDTH = 16;
  localparam int MAX_DIV_W = 32;

  typedef enum logic [1:0] {
    MODE_SAW_UP = 2'b00,
    MODE_SAW_DN = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_SQR    = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  typedef struct packed {
    mode_e                mode;
    logic [MAX_DIV_W-1:0] div;
    logic [MAX_WIDTH-1:0] duty;
  } cfg_t;

endpackage

// File: rtl/da_wavegen_if.sv
// Control/sample bundle of da_wavegen.
//   en, restart      : run enable and synchronous restart pulse
//   cfg_we, cfg_*    : shadow configuration write (mode, divisor, duty)
//   out, sync        : registered DAC sample and period-start pulse
//   cfg_pending      : shadow configuration waiting for a period boundary
// master = controller side, slave = generator side.
interface da_wavegen_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
);
  logic             en;
  logic             restart;
  logic             cfg_we;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_duty;
  logic [WIDTH-1:0] out;
  logic             sync;
  logic             cfg_pending;

  modport master (
    output en, restart, cfg_we, cfg_mode, cfg_div, cfg_duty,
    input  out, sync, cfg_pending
  );

  modport slave (
    input  en, restart, cfg_we, cfg_mode, cfg_div, cfg_duty,
    output out, sync, cfg_pending
  );
endinterface

// File: rtl/da_prescaler.sv
// Rate prescaler: pcnt runs 0..div_act while en is high and a tick is issued
// on the terminal count, giving one tick every div_act+1 enabled clocks.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable (counter holds when low)
//   restart  : clears the counter regardless of en
//   div_act  : active divisor (zero-extended to the package width)
//   tick     : phase-advance strobe
module da_prescaler
  import da_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 restart,
  input  logic [MAX_DIV_W-1:0] div_act,
  output logic                 tick
);

  logic [DIV_W-1:0] pcnt_r;
  logic             term_s;

  assign term_s = (MAX_DIV_W'(pcnt_r) == div_act);
  assign tick   = en && term_s;

  // prescaler counter with restart clear and wrap on tick
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_r <= {DIV_W{1'b0}};
    end else if (restart) begin
      pcnt_r <= {DIV_W{1'b0}};
    end else if (tick) begin
      pcnt_r <= {DIV_W{1'b0}};
    end else if (en) begin
      pcnt_r <= pcnt_r + DIV_W'(1'b1);
    end
  end

endmodule

// File: rtl/da_wavegen.sv
// Parametrised DAC waveform generator (saw up/down, triangle, square).
//   clk, rst : clock, synchronous active-high reset (highest priority)
//   bus      : da_wavegen_if.slave -- enable, restart, shadow config write,
//              registered sample out, sync pulse, cfg_pending flag
// Configuration writes land in a shadow register and only become active at
// a period boundary (or immediately on restart), so the output never shows
// a partial period with mixed settings.
module da_wavegen
  import da_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  da_wavegen_if.slave  bus
);

  localparam logic [WIDTH-1:0]     MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1'b1);
  localparam logic [MAX_WIDTH-1:0] DUTY_RST = MAX_WIDTH'(1'b1) << (WIDTH - 1);
  localparam cfg_t CFG_RST = '{mode: MODE_SAW_UP,
                               div:  {MAX_DIV_W{1'b0}},
                               duty: DUTY_RST};

  cfg_t             cfg_act_r;
  cfg_t             cfg_shd_r;
  cfg_t             cfg_wr_s;
  cfg_t             cfg_bnd_s;
  cfg_t             cfg_rs_s;
  logic [WIDTH-1:0] ph_r;
  logic [WIDTH-1:0] ph_nxt_s;
  dir_e             dir_r;
  dir_e             dir_nxt_s;
  logic             pend_r;
  logic [WIDTH-1:0] out_r;
  logic             sync_r;
  logic             tick_s;
  logic             boundary_s;

  // Sample for a given mode/duty at phase ph.
  function automatic logic [WIDTH-1:0] sample_of(input mode_e mode,
                                                 input logic [MAX_WIDTH-1:0] duty,
                                                 input logic [WIDTH-1:0] ph);
    logic [WIDTH-1:0] s;
    case (mode)
      MODE_SAW_UP: s = ph;
      MODE_SAW_DN: s = MAX - ph;
      MODE_TRI:    s = ph;
      MODE_SQR:    s = (MAX_WIDTH'(ph) < duty) ? MAX : ZERO;
      default:     s = ph;
    endcase
    return s;
  endfunction

  da_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .restart (bus.restart),
    .div_act (cfg_act_r.div),
    .tick    (tick_s)
  );

  // configuration candidates: incoming write, boundary target, restart target
  always_comb begin
    cfg_wr_s = '{mode: mode_e'(bus.cfg_mode),
                 div:  MAX_DIV_W'(bus.cfg_div),
                 duty: MAX_WIDTH'(bus.cfg_duty)};
    if (pend_r) begin
      cfg_bnd_s = cfg_shd_r;
    end else begin
      cfg_bnd_s = cfg_act_r;
    end
    // a write in the restart cycle is the newest shadow and wins
    if (bus.cfg_we) begin
      cfg_rs_s = cfg_wr_s;
    end else begin
      cfg_rs_s = cfg_bnd_s;
    end
  end

  // next phase/direction for one tick under the active mode
  always_comb begin
    ph_nxt_s  = ph_r;
    dir_nxt_s = dir_r;
    if (cfg_act_r.mode == MODE_TRI) begin
      if (dir_r == DIR_UP) begin
        if (ph_r == MAX) begin
          ph_nxt_s  = MAX - ONE;
          dir_nxt_s = DIR_DN;
        end else begin
          ph_nxt_s  = ph_r + ONE;
          dir_nxt_s = DIR_UP;
        end
      end else begin
        if (ph_r == ZERO) begin
          ph_nxt_s  = ONE;
          dir_nxt_s = DIR_UP;
        end else begin
          ph_nxt_s  = ph_r - ONE;
          dir_nxt_s = DIR_DN;
        end
      end
    end else begin
      ph_nxt_s  = ph_r + ONE;
      dir_nxt_s = dir_r;
    end
  end

  assign boundary_s = tick_s && (ph_nxt_s == ZERO);

  // phase, direction, config shadowing and registered sample output
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_r      <= ZERO;
      dir_r     <= DIR_UP;
      cfg_act_r <= CFG_RST;
      cfg_shd_r <= CFG_RST;
      pend_r    <= 1'b0;
      out_r     <= ZERO;
      sync_r    <= 1'b0;
    end else if (bus.restart) begin
      ph_r      <= ZERO;
      dir_r     <= DIR_UP;
      cfg_act_r <= cfg_rs_s;
      cfg_shd_r <= cfg_rs_s;
      pend_r    <= 1'b0;
      out_r     <= sample_of(cfg_rs_s.mode, cfg_rs_s.duty, ZERO);
      sync_r    <= 1'b1;
    end else begin
      if (bus.cfg_we) begin
        cfg_shd_r <= cfg_wr_s;
        pend_r    <= 1'b1;
      end
      if (boundary_s) begin
        // the shadow held before this edge goes live; a same-cycle write
        // stays pending for the following boundary
        ph_r      <= ZERO;
        dir_r     <= DIR_UP;
        cfg_act_r <= cfg_bnd_s;
        out_r     <= sample_of(cfg_bnd_s.mode, cfg_bnd_s.duty, ZERO);
        sync_r    <= 1'b1;
        if (!bus.cfg_we) begin
          pend_r <= 1'b0;
        end
      end else if (tick_s) begin
        ph_r   <= ph_nxt_s;
        dir_r  <= dir_nxt_s;
        out_r  <= sample_of(cfg_act_r.mode, cfg_act_r.duty, ph_nxt_s);
        sync_r <= 1'b0;
      end else begin
        sync_r <= 1'b0;
      end
    end
  end

  assign bus.out         = out_r;
  assign bus.sync        = sync_r;
  assign bus.cfg_pending = pend_r;

endmodule
